// File: rtl/nn_layer_sequencer.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module   : nn_layer_sequencer
// Purpose  : Runs pool -> dense1 -> dense2 -> max with a per-stage timeout trap.
// Revision : 1.0
// ============================================================================
module nn_layer_sequencer #(
  parameter int TIMEOUT = 4096,
  parameter int CNT_W   = 20
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             abort,
  input  logic             pool_done,
  input  logic             dense1_done,
  input  logic             dense2_done,
  input  logic             max_done,
  output logic             layer_clr,
  output logic             pool_en,
  output logic             dense1_en,
  output logic             dense2_en,
  output logic             max_en,
  output logic             busy,
  output logic             nn_done,
  output logic             error,
  output logic [1:0]       err_stage,
  output logic [CNT_W-1:0] total_cycles
);

  localparam int                c_SC_W    = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  localparam logic [c_SC_W-1:0] c_SC_LAST = c_SC_W'(TIMEOUT - 1);
  localparam logic [CNT_W-1:0]  c_TOT_MAX = '1;

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_CLEAR  = 3'd1;
  localparam logic [2:0] S_POOL   = 3'd2;
  localparam logic [2:0] S_DENSE1 = 3'd3;
  localparam logic [2:0] S_DENSE2 = 3'd4;
  localparam logic [2:0] S_MAX    = 3'd5;
  localparam logic [2:0] S_DONE   = 3'd6;
  localparam logic [2:0] S_ERROR  = 3'd7;

  logic [2:0]        r_state, w_state_next;
  logic [c_SC_W-1:0] r_stage_cnt, w_stage_cnt_next;
  logic              w_in_stage, w_done_sel, w_done_ok, w_timeout;
  logic              r_layer_clr, r_pool_en, r_dense1_en, r_dense2_en, r_max_en;
  logic              r_busy, r_nn_done, r_error;
  logic              w_layer_clr, w_pool_en, w_dense1_en, w_dense2_en, w_max_en;
  logic              w_busy, w_nn_done, w_error;
  logic [1:0]        r_err_stage, w_err_stage;
  logic [CNT_W-1:0]  r_total, w_total;

  // State and registered outputs; outputs are decoded from the next state so
  // they line up with the state they describe.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state     <= S_IDLE;
      r_stage_cnt <= '0;
      r_layer_clr <= 1'b0;
      r_pool_en   <= 1'b0;
      r_dense1_en <= 1'b0;
      r_dense2_en <= 1'b0;
      r_max_en    <= 1'b0;
      r_busy      <= 1'b0;
      r_nn_done   <= 1'b0;
      r_error     <= 1'b0;
      r_err_stage <= 2'd0;
      r_total     <= '0;
    end else begin
      r_state     <= w_state_next;
      r_stage_cnt <= w_stage_cnt_next;
      r_layer_clr <= w_layer_clr;
      r_pool_en   <= w_pool_en;
      r_dense1_en <= w_dense1_en;
      r_dense2_en <= w_dense2_en;
      r_max_en    <= w_max_en;
      r_busy      <= w_busy;
      r_nn_done   <= w_nn_done;
      r_error     <= w_error;
      r_err_stage <= w_err_stage;
      r_total     <= w_total;
    end
  end

  always_comb begin
    w_in_stage = (r_state == S_POOL) || (r_state == S_DENSE1) ||
                 (r_state == S_DENSE2) || (r_state == S_MAX);
    w_done_sel = 1'b0;
    case (r_state)
      S_POOL:   w_done_sel = pool_done;
      S_DENSE1: w_done_sel = dense1_done;
      S_DENSE2: w_done_sel = dense2_done;
      S_MAX:    w_done_sel = max_done;
      default:  w_done_sel = 1'b0;
    endcase
    // The first stage cycle never counts, so a done left high from the last run is ignored.
    w_done_ok = w_done_sel && (r_stage_cnt != '0);
    w_timeout = (r_stage_cnt == c_SC_LAST);

    w_state_next = r_state;
    if (abort) begin
      w_state_next = S_IDLE;
    end else begin
      case (r_state)
        S_IDLE, S_DONE, S_ERROR: if (start) w_state_next = S_CLEAR;
        S_CLEAR:  w_state_next = S_POOL;
        S_POOL:   if (w_done_ok) w_state_next = S_DENSE1; else if (w_timeout) w_state_next = S_ERROR;
        S_DENSE1: if (w_done_ok) w_state_next = S_DENSE2; else if (w_timeout) w_state_next = S_ERROR;
        S_DENSE2: if (w_done_ok) w_state_next = S_MAX;    else if (w_timeout) w_state_next = S_ERROR;
        S_MAX:    if (w_done_ok) w_state_next = S_DONE;   else if (w_timeout) w_state_next = S_ERROR;
        default:  w_state_next = S_IDLE;
      endcase
    end
  end

  always_comb begin
    w_layer_clr = (w_state_next == S_CLEAR);
    w_pool_en   = (w_state_next == S_POOL);
    w_dense1_en = (w_state_next == S_DENSE1);
    w_dense2_en = (w_state_next == S_DENSE2);
    w_max_en    = (w_state_next == S_MAX);
    w_busy      = (w_state_next >= S_CLEAR) && (w_state_next <= S_MAX);
    w_nn_done   = (w_state_next == S_DONE);
    w_error     = (w_state_next == S_ERROR);

    w_err_stage = 2'd0;
    if (w_state_next == S_ERROR) begin
      case (r_state)
        S_POOL:   w_err_stage = 2'd0;
        S_DENSE1: w_err_stage = 2'd1;
        S_DENSE2: w_err_stage = 2'd2;
        S_MAX:    w_err_stage = 2'd3;
        default:  w_err_stage = r_err_stage;
      endcase
    end

    w_total = r_total;
    if (w_state_next == S_CLEAR)
      w_total = '0;
    else if (w_in_stage && (r_total != c_TOT_MAX))
      w_total = r_total + CNT_W'(1);

    w_stage_cnt_next = '0;
    if (w_in_stage && (w_state_next == r_state))
      w_stage_cnt_next = r_stage_cnt + c_SC_W'(1);
  end

  assign layer_clr    = r_layer_clr;
  assign pool_en      = r_pool_en;
  assign dense1_en    = r_dense1_en;
  assign dense2_en    = r_dense2_en;
  assign max_en       = r_max_en;
  assign busy         = r_busy;
  assign nn_done      = r_nn_done;
  assign error        = r_error;
  assign err_stage    = r_err_stage;
  assign total_cycles = r_total;

endmodule
`default_nettype wire

// File: tb/tb_nn_layer_sequencer.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module   : tb_nn_layer_sequencer
// Purpose  : Scoreboard bench; u_big (default TIMEOUT) and u_small (TIMEOUT=16).
// Revision : 1.0
// ============================================================================
module tb_nn_layer_sequencer;

  localparam int ST_IDLE = 0, ST_CLEAR = 1, ST_POOL = 2, ST_D1 = 3,
                 ST_D2 = 4, ST_MAX = 5, ST_DONE = 6, ST_ERR = 7;

  typedef struct {
    logic [9:0]  vec;
    logic [19:0] tot;
    bit          chk_tot;
    string       name;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset = 1'b1, start = 1'b0, abort = 1'b0;
  logic [3:0]  dn = 4'b0;
  logic        sel = 1'b0, mon_en = 1'b0;
  int          n_tests = 0, n_fail = 0;
  exp_t        sbq[$];

  logic        clr0, busy0, nd0, er0, clr1, busy1, nd1, er1;
  logic [3:0]  en0, en1;
  logic [1:0]  es0, es1;
  logic [19:0] t0, t1;
  logic [9:0]  v0, v1, m_prev, m_cur;
  logic [19:0] m_tot;

  always #5 clk = ~clk;

  nn_layer_sequencer u_big (
    .clk(clk), .reset(reset), .start(start), .abort(abort),
    .pool_done(dn[0]), .dense1_done(dn[1]), .dense2_done(dn[2]), .max_done(dn[3]),
    .layer_clr(clr0), .pool_en(en0[0]), .dense1_en(en0[1]), .dense2_en(en0[2]),
    .max_en(en0[3]), .busy(busy0), .nn_done(nd0), .error(er0), .err_stage(es0),
    .total_cycles(t0));

  nn_layer_sequencer #(.TIMEOUT(16), .CNT_W(20)) u_small (
    .clk(clk), .reset(reset), .start(start), .abort(abort),
    .pool_done(dn[0]), .dense1_done(dn[1]), .dense2_done(dn[2]), .max_done(dn[3]),
    .layer_clr(clr1), .pool_en(en1[0]), .dense1_en(en1[1]), .dense2_en(en1[2]),
    .max_en(en1[3]), .busy(busy1), .nn_done(nd1), .error(er1), .err_stage(es1),
    .total_cycles(t1));

  // vec = {layer_clr, pool, dense1, dense2, max, busy, nn_done, error, err_stage}
  assign v0 = {clr0, en0[0], en0[1], en0[2], en0[3], busy0, nd0, er0, es0};
  assign v1 = {clr1, en1[0], en1[1], en1[2], en1[3], busy1, nd1, er1, es1};

  function automatic logic [9:0] ev(input int st, input logic [1:0] es);
    logic [9:0] v;
    v = '0;
    case (st)
      ST_CLEAR: begin v[9] = 1'b1; v[4] = 1'b1; end
      ST_POOL, ST_D1, ST_D2, ST_MAX: begin v[8 - (st - ST_POOL)] = 1'b1; v[4] = 1'b1; end
      ST_DONE: v[3] = 1'b1;
      ST_ERR:  begin v[2] = 1'b1; v[1:0] = es; end
      default: v = '0;
    endcase
    return v;
  endfunction

  function automatic logic [9:0] cur_vec();
    return sel ? v1 : v0;
  endfunction

  task automatic push(input int st, input logic [1:0] es, input int tot, input bit ct, input string nm);
    exp_t e;
    e.vec = ev(st, es); e.tot = 20'(tot); e.chk_tot = ct; e.name = nm;
    sbq.push_back(e);
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_bit(input int b, input string nm);
    int n;
    logic [9:0] v;
    n = 0;
    v = cur_vec();
    while (!v[b] && n < 5000) begin
      tick();
      n++;
      v = cur_vec();
    end
    if (!v[b]) begin
      n_tests++;
      n_fail++;
      $display("FAIL wait_%s: got 0 expected 1 within 5000 cycles", nm);
    end
  endtask

  // Stage k lasts d cycles: its done is raised on the d-th cycle in the stage.
  task automatic run_stage(input int k, input int d);
    wait_bit(8 - k, "stage_en");
    repeat (d - 1) tick();
    dn[k] = 1'b1;
    tick();
    dn[k] = 1'b0;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic push_run(input int p, input int a, input int b, input int c);
    push(ST_CLEAR, 2'd0, 0, 1'b1, "clear");
    push(ST_POOL,  2'd0, 0, 1'b1, "pool");
    push(ST_D1,    2'd0, p, 1'b1, "dense1");
    push(ST_D2,    2'd0, p + a, 1'b1, "dense2");
    push(ST_MAX,   2'd0, p + a + b, 1'b1, "max");
    push(ST_DONE,  2'd0, p + a + b + c, 1'b1, "done");
  endtask

  // Monitor: every change of the observed output vector consumes one expectation.
  always @(negedge clk) begin
    exp_t e;
    m_cur = cur_vec();
    m_tot = sel ? t1 : t0;
    if (mon_en) begin
      n_tests++;
      if ($countones(m_cur[8:5]) > 1) begin
        n_fail++;
        $display("FAIL onehot: enables %b expected at most one set", m_cur[8:5]);
      end
      if (m_cur !== m_prev) begin
        n_tests++;
        if (sbq.size() == 0) begin
          n_fail++;
          $display("FAIL unexpected_change: got %b expected no change from %b", m_cur, m_prev);
        end else begin
          e = sbq.pop_front();
          if (m_cur !== e.vec || (e.chk_tot && m_tot !== e.tot)) begin
            n_fail++;
            $display("FAIL %s: got vec=%b tot=%0d expected vec=%b tot=%0d",
                     e.name, m_cur, m_tot, e.vec, e.tot);
          end
        end
      end
    end
    m_prev = m_cur;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    repeat (3) tick();
    chk("reset_vec_big", 32'(v0), 32'(ev(ST_IDLE, 2'd0)));
    chk("reset_tot_big", 32'(t0), 32'd0);
    chk("reset_vec_small", 32'(v1), 32'(ev(ST_IDLE, 2'd0)));
    reset = 1'b0;
    tick();
    repeat (3) tick();
    mon_en = 1'b1;

    // Nominal run: stage lengths 197/10/20/3 give 230 cycles in total.
    push_run(197, 10, 20, 3);
    pulse_start();
    run_stage(0, 197);
    run_stage(1, 10);
    run_stage(2, 20);
    run_stage(3, 3);
    wait_bit(3, "nn_done");
    repeat (3) tick();

    // Stale dense1_done held high: DENSE1 must still last two cycles.
    dn[1] = 1'b1;
    push_run(5, 2, 4, 2);
    pulse_start();
    run_stage(0, 5);
    wait_bit(6, "dense2_en");
    dn[1] = 1'b0;
    run_stage(2, 4);
    run_stage(3, 2);
    wait_bit(3, "nn_done");
    repeat (3) tick();

    // Switch the monitor to the TIMEOUT=16 instance.
    mon_en = 1'b0;
    reset = 1'b1;
    tick();
    sel = 1'b1;
    tick();
    reset = 1'b0;
    repeat (2) tick();
    mon_en = 1'b1;

    // Timeout in DENSE2 after 16 cycles.
    push(ST_CLEAR, 2'd0, 0, 1'b1, "to_clear");
    push(ST_POOL,  2'd0, 0, 1'b1, "to_pool");
    push(ST_D1,    2'd0, 3, 1'b1, "to_dense1");
    push(ST_D2,    2'd0, 6, 1'b1, "to_dense2");
    push(ST_ERR,   2'd2, 22, 1'b1, "to_error");
    pulse_start();
    run_stage(0, 3);
    run_stage(1, 3);
    wait_bit(2, "error");
    repeat (5) tick();

    // max_done on the last allowed cycle wins over the timeout.
    push_run(2, 2, 2, 16);
    pulse_start();
    run_stage(0, 2);
    run_stage(1, 2);
    run_stage(2, 2);
    run_stage(3, 16);
    wait_bit(3, "nn_done");
    repeat (3) tick();

    // Abort together with start in DENSE1, then a normal run.
    push(ST_CLEAR, 2'd0, 0, 1'b1, "ab_clear");
    push(ST_POOL,  2'd0, 0, 1'b1, "ab_pool");
    push(ST_D1,    2'd0, 3, 1'b1, "ab_dense1");
    push(ST_IDLE,  2'd0, 0, 1'b0, "ab_idle");
    pulse_start();
    run_stage(0, 3);
    tick();
    abort = 1'b1;
    start = 1'b1;
    tick();
    abort = 1'b0;
    start = 1'b0;
    repeat (3) tick();
    push_run(2, 2, 2, 2);
    pulse_start();
    run_stage(0, 2);
    run_stage(1, 2);
    run_stage(2, 2);
    run_stage(3, 2);
    wait_bit(3, "nn_done");
    repeat (3) tick();

    // Asynchronous reset in the middle of POOL.
    push(ST_CLEAR, 2'd0, 0, 1'b1, "rs_clear");
    push(ST_POOL,  2'd0, 0, 1'b1, "rs_pool");
    push(ST_IDLE,  2'd0, 0, 1'b1, "rs_idle");
    pulse_start();
    wait_bit(8, "pool_en");
    repeat (3) tick();
    #2;
    reset = 1'b1;
    #1;
    chk("async_pool_en", 32'(en1[0]), 32'd0);
    chk("async_busy", 32'(busy1), 32'd0);
    chk("async_total", 32'(t1), 32'd0);
    repeat (2) tick();
    reset = 1'b0;
    repeat (2) tick();
    push_run(2, 2, 2, 2);
    pulse_start();
    run_stage(0, 2);
    run_stage(1, 2);
    run_stage(2, 2);
    run_stage(3, 2);
    wait_bit(3, "nn_done");
    repeat (4) tick();

    chk("scoreboard_drained", 32'(sbq.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/nn_layer_sequencer.md
NN_LAYER_SEQUENCER -- requirements
Module: nn_layer_sequencer

Interface
REQ-001 The block SHALL have parameter TIMEOUT, default 4096, the maximum cycles allowed per stage before the error trap.
REQ-002 The block SHALL have parameter CNT_W, default 20, the width of the total cycle counter.
REQ-003 The block SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-004 The block SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-005 The block SHALL have port start  input  1  run request; level-sampled; accepted only in IDLE, DONE or ERROR.
REQ-006 The block SHALL have port abort  input  1  synchronous abort to IDLE from any state.
REQ-007 The block SHALL have ports pool_done, dense1_done, dense2_done, max_done  input  1 each  level done flags from the four layers.
REQ-008 The block SHALL have port layer_clr  output  1  one-cycle clear pulse to all layers at run start.
REQ-009 The block SHALL have ports pool_en, dense1_en, dense2_en, max_en  output  1 each  stage enables; at most one high at a time.
REQ-010 The block SHALL have port busy  output  1  high in CLEAR, POOL, DENSE1, DENSE2 and MAX.
REQ-011 The block SHALL have port nn_done  output  1  high while in DONE.
REQ-012 The block SHALL have port error  output  1  high while in ERROR.
REQ-013 The block SHALL have port err_stage  output  2  stage that timed out: 0 pool, 1 dense1, 2 dense2, 3 max.
REQ-014 The block SHALL have port total_cycles  output  CNT_W  cycle count of the last or current run.

Function
REQ-015 The FSM SHALL have states IDLE, CLEAR, POOL, DENSE1, DENSE2, MAX, DONE and ERROR; all outputs SHALL be registered.
REQ-016 IDLE/DONE/ERROR with start=1 -> CLEAR: layer_clr=1 for exactly that cycle, total_cycles cleared to 0, error/err_stage cleared.
REQ-017 CLEAR SHALL always move to POOL on the next edge.
REQ-018 Stage chain: POOL -> DENSE1 -> DENSE2 -> MAX -> DONE; each stage's enable is high for every cycle the FSM is in that stage.
REQ-019 stage_cnt SHALL reset to 0 on stage entry and increment every cycle in the stage.
REQ-020 The active stage's done input SHALL be honoured only when stage_cnt >= 1, which rejects stale done from the previous run.
REQ-021 On an honoured done the FSM SHALL advance on the same edge: current enable low and next enable high in the following cycle, with no gap cycle and no overlap.
REQ-022 Done inputs of non-active stages SHALL be ignored.
REQ-023 If stage_cnt == TIMEOUT-1 and no done is honoured, the FSM SHALL go to ERROR, set err_stage and drop all enables.
REQ-024 If done and timeout occur in the same cycle, done SHALL win.
REQ-025 total_cycles SHALL increment each cycle in POOL..MAX, saturate at 2^CNT_W-1, and hold in DONE/ERROR/IDLE.
REQ-026 DONE and ERROR SHALL persist until start or abort; start while busy=1 SHALL be ignored.
REQ-027 abort=1 SHALL force IDLE next edge from any state, clear all enables, and assert neither nn_done nor error.
REQ-028 abort SHALL take priority over start, done and timeout in the same cycle.
REQ-029 In IDLE with start=0 all outputs SHALL hold; layer_clr SHALL never be high outside the CLEAR cycle.

Reset
REQ-030 reset=1 SHALL asynchronously force IDLE with all enables, layer_clr, busy, nn_done, error, err_stage, total_cycles and stage_cnt at 0.
REQ-031 Reset mid-run SHALL drop enables immediately without waiting for a clock edge; first start after release SHALL begin a clean run.

Verification
REQ-032 Nominal: start pulse; pool_done 196 cycles after POOL entry, then 10, 20 and 3 cycles for the later stages -> enables one-hot in order, nn_done=1, total_cycles=230, layer_clr one pulse.
REQ-033 Stale done: dense1_done held high from the previous run, start -> in DENSE1, cycle stage_cnt=0 ignored; advance only at stage_cnt>=1.
REQ-034 Timeout: TIMEOUT=16, dense2_done never asserted -> ERROR after 16 DENSE2 cycles, err_stage=2, all enables 0, nn_done=0.
REQ-035 Done and timeout collide: max_done high at stage_cnt=TIMEOUT-1 -> DONE, error=0.
REQ-036 Abort and start in the same cycle during DENSE1 -> IDLE, no layer_clr, outputs 0; next start runs normally.
REQ-037 Async reset asserted mid-POOL between edges -> pool_en=0 before the next edge; total_cycles=0.
